mem_access_stage: RTL
=====================

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, data-bus address width.
REQ-002 SHALL have ports:
  clk  input  1  single clock, rising edge
  rst  input  1  synchronous, active-high reset
  ex_valid_i  input  1  execute-stage instruction valid
  ex_ready_o  output  1  stage can accept a new instruction
  opcode_info_i  input  10  decoded opcode flags; bit4 = load, bit5 = store
  funct3_i  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
  alu_result_i  input  32  effective address or ALU result
  store_data_i  input  32  rs2 data for stores
  rd_id_i  input  5  destination register
  rd_write_en_i  input  1  destination write enable
  mem_req_o  output  1  data-bus request
  mem_we_o  output  1  1 = write
  mem_addr_o  output  ADDR_W  word-aligned address ({addr[31:2],2'b00})
  mem_wdata_o  output  32  lane-shifted store data
  mem_wstrb_o  output  4  byte strobes
  mem_rdata_i  input  32  read data, valid with ack
  mem_ack_i  input  1  bus completion
  regW_valid_o  output  1  writeback register valid
  regW_opcode_info_o  output  10  registered opcode_info
  regW_alu_result_o  output  32  registered alu_result
  regW_mem_rdata_o  output  32  aligned, extended load data
  regW_rd_id_o  output  5  registered rd_id
  regW_rd_write_en_o  output  1  registered rd_write_en
  misalign_o  output  1  one-cycle pulse, misaligned access rejected

Function
REQ-003 SHALL implement FSM states IDLE, BUS, and nothing else.
REQ-004 ex_ready_o SHALL be 1 in IDLE, 0 in BUS.
REQ-005 IDLE, ex_valid_i=1, non-memory op: regW_* SHALL load inputs at the next edge, regW_valid_o=1, regW_mem_rdata_o=0; latency 1 cycle.
REQ-006 IDLE, ex_valid_i=1, aligned load/store: SHALL latch the instruction, assert mem_req_o at the next edge, go to BUS.
REQ-007 Alignment: H requires addr[0]=0; W requires addr[1:0]=00; B is always aligned.
REQ-008 Misaligned load/store: no bus request; misalign_o=1 and regW_valid_o=1 with regW_rd_write_en_o forced 0, both for one cycle.
REQ-009 In BUS, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o and mem_wstrb_o SHALL hold stable until the cycle mem_ack_i=1.
REQ-010 Acknowledge: mem_ack_i is sampled only while mem_req_o=1 and may arrive in the first request cycle; mem_ack_i while idle SHALL be ignored.
REQ-011 Acknowledge in BUS:
  - next edge: mem_req_o=0, regW_valid_o=1, return to IDLE.
  - minimum load/store latency: 2 cycles from acceptance to regW_valid_o.
REQ-012 Store strobes and data:
  - SB: strobe = 4'b0001<<addr[1:0], data = {4{byte}}.
  - SH: strobe = 4'b0011<<addr[1:0], data = {2{half}}.
  - SW: strobe = 4'b1111, data unchanged.
REQ-013 Load data: lane = mem_rdata_i>>(8*addr[1:0]).
  - LB/LH: sign-extend the lane to 32 bits.
  - LBU/LHU: zero-extend the lane to 32 bits.
  - LW: use the word unchanged.
REQ-014 Stores SHALL drive regW_mem_rdata_o=0; loads drive mem_we_o=0, mem_wstrb_o=0.
REQ-015 regW_valid_o SHALL pulse for exactly one cycle per accepted instruction; all regW_* hold their values otherwise.
REQ-016 Load and store both set: SHALL be treated as a load.

Reset
REQ-017 rst=1 at a rising edge SHALL force:
  - state IDLE.
  - mem_req_o=0, mem_we_o=0, mem_wstrb_o=0, mem_addr_o=0, mem_wdata_o=0.
  - regW_valid_o=0, regW_rd_write_en_o=0, misalign_o=0.
  - every other regW_* output = 0.
REQ-018 Reset in BUS SHALL abandon the transaction; a mem_ack_i arriving after reset SHALL be ignored.

Verification
REQ-019 ADD: alu_result=0x1234, rd=5, we=1 -> next cycle regW_valid=1, regW_alu_result=0x1234, rd_id=5, no mem_req.
REQ-020 LB: addr 0x103, rdata 0x80FF_0000, ack after 3 wait cycles -> mem_addr=0x100; regW_mem_rdata=0xFFFF_FF80; ex_ready low for 4 cycles.
REQ-021 SH: addr 0x202, data 0x0000_ABCD, ack same cycle -> wstrb=1100, wdata=0xABCD_ABCD, we=1, regW_valid 2 cycles after acceptance.
REQ-022 LW: addr 0x301 -> misalign_o pulse, no mem_req, regW_rd_write_en=0.
REQ-023 LHU: addr 0x402, rdata 0x8001_0000 -> regW_mem_rdata=0x0000_8001.
REQ-024 Reset in BUS with ack asserted one cycle later -> outputs zero, state IDLE, no regW_valid pulse.

Source files
------------

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: turns execute-stage loads/stores into single data-bus
// transactions and registers every accepted instruction for writeback.
module mem_access_stage #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid_i,
    output logic              ex_ready_o,
    input  logic [9:0]        opcode_info_i,
    input  logic [2:0]        funct3_i,
    input  logic [31:0]       alu_result_i,
    input  logic [31:0]       store_data_i,
    input  logic [4:0]        rd_id_i,
    input  logic              rd_write_en_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic [3:0]        mem_wstrb_o,
    input  logic [31:0]       mem_rdata_i,
    input  logic              mem_ack_i,
    output logic              regW_valid_o,
    output logic [9:0]        regW_opcode_info_o,
    output logic [31:0]       regW_alu_result_o,
    output logic [31:0]       regW_mem_rdata_o,
    output logic [4:0]        regW_rd_id_o,
    output logic              regW_rd_write_en_o,
    output logic              misalign_o,
    output logic              fsm_state_o
);

    // Handshakes: an instruction transfers on a rising edge where ex_valid_i && ex_ready_o;
    // a bus transaction completes on a rising edge where mem_req_o && mem_ack_i, and the
    // request fields hold stable from assertion until that edge.

    typedef enum logic {
        IDLE = 1'b0,
        BUS  = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic accept;
    logic is_load;
    logic is_store;
    logic is_mem;
    logic misaligned;
    logic bus_done;

    logic [31:0] st_wdata;
    logic [3:0]  st_wstrb;
    logic [31:0] word_addr;

    logic        lat_is_load;
    logic [2:0]  lat_funct3;
    logic [1:0]  lat_addr_lo;
    logic [9:0]  lat_opcode_info;
    logic [31:0] lat_alu_result;
    logic [4:0]  lat_rd_id;
    logic        lat_rd_write_en;

    logic [31:0] ld_lane;
    logic [31:0] ld_data;

    assign ex_ready_o  = (state == IDLE);
    assign fsm_state_o = (state == BUS);
    assign accept      = ex_valid_i && (state == IDLE);
    // A load flag wins when both load and store are flagged.
    assign is_load     = opcode_info_i[4];
    assign is_store    = opcode_info_i[5] && !opcode_info_i[4];
    assign is_mem      = is_load || is_store;
    assign bus_done    = (state == BUS) && mem_ack_i;
    assign word_addr   = {alu_result_i[31:2], 2'b00};

    always_comb begin
        misaligned = 1'b0;
        case (funct3_i[1:0])
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = alu_result_i[0];
            default: misaligned = |alu_result_i[1:0];
        endcase
    end

    always_comb begin
        st_wdata = store_data_i;
        st_wstrb = 4'b1111;
        case (funct3_i[1:0])
            2'b00: begin
                st_wdata = {4{store_data_i[7:0]}};
                st_wstrb = 4'b0001 << alu_result_i[1:0];
            end
            2'b01: begin
                st_wdata = {2{store_data_i[15:0]}};
                st_wstrb = 4'b0011 << alu_result_i[1:0];
            end
            default: begin
                st_wdata = store_data_i;
                st_wstrb = 4'b1111;
            end
        endcase
    end

    // Load alignment uses the latched byte offset, since the bus returns a full word.
    always_comb begin
        ld_lane = mem_rdata_i >> {lat_addr_lo, 3'b000};
        ld_data = mem_rdata_i;
        case (lat_funct3)
            3'b000:  ld_data = {{24{ld_lane[7]}}, ld_lane[7:0]};
            3'b001:  ld_data = {{16{ld_lane[15]}}, ld_lane[15:0]};
            3'b100:  ld_data = {24'h0, ld_lane[7:0]};
            3'b101:  ld_data = {16'h0, ld_lane[15:0]};
            default: ld_data = mem_rdata_i;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept && is_mem && !misaligned) state_next = BUS;
            BUS:  if (mem_ack_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req_o          <= 1'b0;
            mem_we_o           <= 1'b0;
            mem_addr_o         <= '0;
            mem_wdata_o        <= '0;
            mem_wstrb_o        <= '0;
            regW_valid_o       <= 1'b0;
            regW_opcode_info_o <= '0;
            regW_alu_result_o  <= '0;
            regW_mem_rdata_o   <= '0;
            regW_rd_id_o       <= '0;
            regW_rd_write_en_o <= 1'b0;
            misalign_o         <= 1'b0;
            lat_is_load        <= 1'b0;
            lat_funct3         <= '0;
            lat_addr_lo        <= '0;
            lat_opcode_info    <= '0;
            lat_alu_result     <= '0;
            lat_rd_id          <= '0;
            lat_rd_write_en    <= 1'b0;
        end else begin
            regW_valid_o <= 1'b0;
            misalign_o   <= 1'b0;
            if (accept) begin
                if (!is_mem || misaligned) begin
                    // Retire immediately; a rejected access must not write a register.
                    regW_valid_o       <= 1'b1;
                    regW_opcode_info_o <= opcode_info_i;
                    regW_alu_result_o  <= alu_result_i;
                    regW_mem_rdata_o   <= '0;
                    regW_rd_id_o       <= rd_id_i;
                    regW_rd_write_en_o <= rd_write_en_i && !is_mem;
                    misalign_o         <= is_mem;
                end else begin
                    lat_is_load     <= is_load;
                    lat_funct3      <= funct3_i;
                    lat_addr_lo     <= alu_result_i[1:0];
                    lat_opcode_info <= opcode_info_i;
                    lat_alu_result  <= alu_result_i;
                    lat_rd_id       <= rd_id_i;
                    lat_rd_write_en <= rd_write_en_i;
                    mem_req_o       <= 1'b1;
                    mem_we_o        <= is_store;
                    mem_addr_o      <= ADDR_W'(word_addr);
                    mem_wdata_o     <= is_store ? st_wdata : 32'h0;
                    mem_wstrb_o     <= is_store ? st_wstrb : 4'h0;
                end
            end else if (bus_done) begin
                mem_req_o          <= 1'b0;
                mem_we_o           <= 1'b0;
                mem_addr_o         <= '0;
                mem_wdata_o        <= '0;
                mem_wstrb_o        <= '0;
                regW_valid_o       <= 1'b1;
                regW_opcode_info_o <= lat_opcode_info;
                regW_alu_result_o  <= lat_alu_result;
                regW_mem_rdata_o   <= lat_is_load ? ld_data : 32'h0;
                regW_rd_id_o       <= lat_rd_id;
                regW_rd_write_en_o <= lat_rd_write_en;
            end
        end
    end

endmodule
